// File: rtl/os_skew_feeder.sv
// Operand skew feeder for an N x N output-stationary systolic array.
// Ports: clk, rst_n (async, active-low); start/k_len begin a job;
//   in_valid/in_ready handshake one A column + B row per beat (a_vec, b_vec);
//   a_edge/b_edge drive the array's left/top edges with per-lane skew;
//   compute_en enables (high) or clears (low) the PE accumulators;
//   result_valid marks final sums until res_ack; busy is high outside IDLE.
module os_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic            compute_en,
    output logic            result_valid,
    input  logic            res_ack,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_HOLD
    } state_t;

    localparam int FW = $clog2(2 * N) + 1;

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_klen;
    logic [7:0]     r_cnt;
    logic [FW-1:0]  r_fcnt;
    logic           r_ce;
    logic           w_ready;
    logic           w_rv;
    logic           w_feed;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_rv    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (k_len == 8'd0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (in_valid && (r_cnt == r_klen - 8'd1)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fcnt == FW'(2 * N - 1)) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_rv = 1'b1;
                if (res_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_feed       = w_ready & in_valid;
    assign in_ready     = w_ready;
    assign result_valid = w_rv;
    assign busy         = (r_state != S_IDLE);
    assign compute_en   = r_ce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_klen  <= 8'd0;
            r_cnt   <= 8'd0;
            r_fcnt  <= '0;
            r_ce    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Follows the next state so PEs clear the cycle after IDLE.
            r_ce    <= (w_next != S_IDLE);
            if (r_state == S_IDLE) begin
                r_cnt <= 8'd0;
                if (start) begin
                    r_klen <= k_len;
                end
            end else if (w_feed) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_FLUSH) begin
                r_fcnt <= r_fcnt + FW'(1);
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Lane g is delayed 1+g cycles; its last stage drives the edge directly.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [DW-1:0] r_a [0:g];
        logic [DW-1:0] r_b [0:g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= g; s++) begin
                    r_a[s] <= '0;
                    r_b[s] <= '0;
                end
            end else begin
                r_a[0] <= w_feed ? a_vec[g*DW +: DW] : '0;
                r_b[0] <= w_feed ? b_vec[g*DW +: DW] : '0;
                for (int s = 1; s <= g; s++) begin
                    r_a[s] <= r_a[s-1];
                    r_b[s] <= r_b[s-1];
                end
            end
        end

        assign a_edge[g*DW +: DW] = r_a[g];
        assign b_edge[g*DW +: DW] = r_b[g];
    end

endmodule

// File: tb/tb_os_skew_feeder.sv
// Self-checking bench for os_skew_feeder: job timeline + skew + PE-array sums.
module tb_os_skew_feeder;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int W    = N * DW;
    localparam int MAXC = 1024;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   k_len;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_vec;
    logic [W-1:0] b_vec;
    logic [W-1:0] a_edge;
    logic [W-1:0] b_edge;
    logic         compute_en;
    logic         result_valid;
    logic         res_ack;
    logic         busy;

    os_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .a_edge      (a_edge),
        .b_edge      (b_edge),
        .compute_en  (compute_en),
        .result_valid(result_valid),
        .res_ack     (res_ack),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output-stationary PE array fed by the feeder edges.
    logic signed [DW-1:0] pa  [N][N];
    logic signed [DW-1:0] pb  [N][N];
    logic signed [15:0]   acc [N][N];
    logic signed [DW-1:0] m_ain;
    logic signed [DW-1:0] m_bin;
    logic signed [15:0]   m_prod;

    always @(posedge clk or negedge rst_n) begin
        for (int i = N - 1; i >= 0; i--) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (!rst_n || !compute_en) begin
                    pa[i][j]  = '0;
                    pb[i][j]  = '0;
                    acc[i][j] = '0;
                end else begin
                    m_ain = (j == 0) ? a_edge[i*DW +: DW] : pa[i][j-1];
                    m_bin = (i == 0) ? b_edge[j*DW +: DW] : pb[i-1][j];
                    m_prod = m_ain * m_bin;
                    acc[i][j] = acc[i][j] + m_prod;
                    pa[i][j]  = m_ain;
                    pb[i][j]  = m_bin;
                end
            end
        end
    end

    logic [W-1:0] ea [MAXC];
    logic [W-1:0] eb [MAXC];
    bit           vv [MAXC];
    int           sum [N][N];

    // Lane i at cycle c carries what entered the lane at cycle c-1-i.
    function automatic logic [W-1:0] skew(input int c, input bit is_a);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = c - 1 - i;
            if (idx >= 0) begin
                r[i*DW +: DW] = is_a ? ea[idx][i*DW +: DW]
                                     : eb[idx][i*DW +: DW];
            end
        end
        return r;
    endfunction

    task automatic chk_sums(input int c);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk($sformatf("pe%0d%0d c%0d", i, j, c),
                    64'(acc[i][j]) & 64'hffff, 64'(sum[i][j]) & 64'hffff);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a_edge"}, a_edge, 0);
        chk({tag, " b_edge"}, b_edge, 0);
        chk({tag, " ce"}, compute_en, 0);
        chk({tag, " rv"}, result_valid, 0);
        chk({tag, " ready"}, in_ready, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    // dmode: 0 random, 1 all ones, 2 identity, 3 all -128
    // vmode: 0 continuous, 1 random bubbles, 2 two bubbles after beat 1
    task automatic run_job(input int k, input int dmode, input int vmode,
                           input int h, input int rst_at);
        int L, E, nb, c, ph;
        logic [W-1:0] av, bv;
        for (int x = 0; x < MAXC; x++) vv[x] = 1'b0;
        nb = 0;
        L  = 0;
        if (k > 0) begin
            c = 1;
            while (nb < k) begin
                case (vmode)
                    0: vv[c] = 1'b1;
                    1: vv[c] = ($urandom_range(3) != 0) || (c > 800);
                    default: vv[c] = !(c == 2 || c == 3);
                endcase
                if (vv[c]) nb++;
                L = c;
                c++;
            end
        end
        E  = L + 2 * N + h + 1;
        nb = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) sum[i][j] = 0;
        for (c = 0; c <= E; c++) begin
            if (c == 0 || c == E) ph = 0;
            else if (c <= L) ph = 1;
            else if (c <= L + 2 * N) ph = 2;
            else ph = 3;
            av = W'($urandom);
            bv = W'($urandom);
            if (ph == 1 && vv[c]) begin
                case (dmode)
                    1: begin av = {N{8'd1}}; bv = {N{8'd1}}; end
                    2: begin
                        av = '0;
                        bv = '0;
                        if (nb < N) begin
                            av[nb*DW +: DW] = 8'd1;
                            bv[nb*DW +: DW] = 8'd1;
                        end
                    end
                    3: begin av = {N{8'h80}}; bv = {N{8'h80}}; end
                    default: ;
                endcase
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        sum[i][j] += int'($signed(av[i*DW +: DW]))
                                   * int'($signed(bv[j*DW +: DW]));
                nb++;
                ea[c] = av;
                eb[c] = bv;
            end else begin
                ea[c] = '0;
                eb[c] = '0;
            end
            a_vec    = av;
            b_vec    = bv;
            in_valid = (ph == 1) ? vv[c] : 1'($urandom_range(1));
            k_len    = (c == 0) ? 8'(k) : 8'($urandom);
            start    = (c == 0) ? 1'b1
                     : (c == E) ? 1'b0 : 1'($urandom_range(1));
            res_ack  = (ph == 3) ? (c == E - 1)
                     : (ph == 0) ? 1'b0 : 1'($urandom_range(1));
            @(negedge clk);
            chk($sformatf("busy c%0d", c), busy, ph != 0);
            chk($sformatf("ready c%0d", c), in_ready, ph == 1);
            chk($sformatf("ce c%0d", c), compute_en, ph != 0);
            chk($sformatf("rv c%0d", c), result_valid, ph == 3);
            chk($sformatf("a_edge c%0d", c), a_edge, skew(c, 1'b1));
            chk($sformatf("b_edge c%0d", c), b_edge, skew(c, 1'b0));
            if (ph == 3 && (c == L + 2 * N + 1 || c == E - 1)) chk_sums(c);
            if (c == rst_at) begin
                rst_n = 1'b0;
                start = 1'b1;
                #1;
                chk_zero("rst now");
                repeat (3) @(posedge clk);
                #1;
                chk_zero("rst held");
                start = 1'b0;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("rst idle busy", busy, 0);
                for (int x = 0; x < MAXC; x++) begin
                    ea[x] = '0;
                    eb[x] = '0;
                end
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        k_len    = 8'd0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        res_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("post reset");
        run_job(1, 1, 0, 2, -1);
        run_job(4, 2, 0, 3, -1);
        run_job(3, 0, 0, 1, -1);
        run_job(3, 0, 2, 1, -1);
        run_job(0, 0, 0, 2, -1);
        run_job(2, 3, 0, 1, -1);
        run_job(5, 0, 0, 2, 8);
        run_job(3, 0, 1, 1, -1);
        for (int n = 0; n < 20; n++) begin
            run_job(int'($urandom_range(12)), 0, 1,
                    int'($urandom_range(4, 1)), -1);
        end
        run_job(255, 0, 1, 1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/os_skew_feeder.md
OS_SKEW_FEEDER -- requirements
Module: os_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning array rows = columns.
REQ-002 SHALL have parameter DW, default 8, meaning signed operand width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin one tile job; sampled in IDLE only.
REQ-006 SHALL have port k_len  input  8  number of K beats in the job, 0..255; latched on accepted start.
REQ-007 SHALL have port in_valid  input  1  a_vec/b_vec beat valid.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-009 SHALL have port a_vec  input  N*DW  one A column (lane i = row i, lane 0 in LSBs).
REQ-010 SHALL have port b_vec  input  N*DW  one B row (lane j = column j).
REQ-011 SHALL have port a_edge  output  N*DW  skewed A into the array's left-edge PEs.
REQ-012 SHALL have port b_edge  output  N*DW  skewed B into the array's top-edge PEs.
REQ-013 SHALL have port compute_en  output  1  broadcast to every PE; low clears PE accumulators.
REQ-014 SHALL have port result_valid  output  1  all PE accumulators hold final sums.
REQ-015 SHALL have port res_ack  input  1  downstream has read the results.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, HOLD.
REQ-018 IDLE: start=1 & k_len>0 -> LOAD; start=1 & k_len=0 -> FLUSH; otherwise stay.
REQ-019 LOAD: in_ready=1; 8-bit beat counter increments per accepted beat; after beat k_len accepted -> FLUSH on the next edge.
REQ-020 LOAD with in_valid=0: no counter change; zeros enter every skew lane that cycle (bubble, no stall).
REQ-021 In all states other than LOAD, in_ready=0 and zeros enter every skew lane.
REQ-022 Lane i of A and lane j of B SHALL pass through 1+i and 1+j register stages respectively; all edge outputs registered.
REQ-023 FLUSH SHALL last exactly 2*N cycles (8 for N=4), covering skew drain, PE hop, multiplier latency and accumulate; then -> HOLD.
REQ-024 compute_en SHALL be registered, high in LOAD, FLUSH and HOLD, low in IDLE; first high on the cycle after start is accepted.
REQ-025 HOLD: result_valid=1, edges are zero, so accumulators stay constant; res_ack=1 -> IDLE next edge.
REQ-026 On return to IDLE, compute_en drops the same edge, so PEs clear one cycle later; result_valid drops with it.
REQ-027 start in any state other than IDLE SHALL be ignored; res_ack outside HOLD SHALL be ignored.
REQ-028 start and res_ack both high in HOLD: leave HOLD via res_ack only; start is not captured (ignored).
REQ-029 Operands SHALL pass unmodified (no sign change, no arithmetic); widths preserved.
REQ-030 Back-to-back jobs: minimum one IDLE cycle between HOLD exit and the next LOAD/FLUSH entry.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, beat counter 0, all skew registers 0, a_edge=0, b_edge=0, compute_en=0, result_valid=0, in_ready=0, busy=0.
REQ-032 Reset asserted mid-job SHALL abort the job; after release the block waits in IDLE for a new start.

Verification
REQ-033 N=4, k_len=1, beat a_vec lanes all 1, b_vec lanes all 1 at cycle t -> a_edge lane i =1 only at t+1+i; result_valid at t+1+2N (t+9); all 16 PE sums = 1.
REQ-034 k_len=4, A=B=identity fed continuously -> 4x4 array model result = identity; result_valid exactly 2N cycles after last beat accepted.
REQ-035 k_len=3 with in_valid low for 2 cycles between beats 1 and 2 -> same sums as without bubble; FLUSH start delayed by 2 cycles.
REQ-036 k_len=0 start -> LOAD skipped, FLUSH 8 cycles, HOLD with all sums 0; res_ack -> IDLE, compute_en low.
REQ-037 Signed corner: a=-128, b=-128, k_len=2 -> each PE sum = 32768 wraps in 16-bit to -32768; feeder edges carry exactly 0x80.
REQ-038 rst_n pulsed during FLUSH -> all outputs 0 immediately; start ignored while rst_n low; fresh job after release completes correctly.
